// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the data-memory stage controller.
// BASE_ADDR/MEM_WORDS defaults are also used by the memory model.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_BASE_ADDR = 1024;
    localparam int DEF_MEM_WORDS = 65465;

    // Word-aligned and inside [base, base + 4*words). The subtraction only matters
    // once addr >= base holds, so it never wraps into a false accept.
    function automatic logic addr_in_range(input logic [63:0] addr,
                                           input logic [63:0] base,
                                           input logic [63:0] words);
        logic [63:0] off;
        off = addr - base;
        return (addr[1:0] == 2'b00) && (addr >= base) && ((off >> 2) < words);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state down-counter: loads a start value, counts down to zero and
// flags the terminal count.
module mem_wait_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_stage_controller.sv
// Data-memory initiator for the MEM stage: turns one-cycle load/store requests
// into fixed-latency memory accesses, stalling the pipeline through ready.
//
//  state   | meaning
//  IDLE    | evaluate request; fault or accept, ready unless accepting
//  WAIT    | access in flight; read strobe every cycle, write strobe on last
//  DONE    | one-cycle completion, ready=1, pipeline advances
module mem_stage_controller
    import mem_ctrl_pkg::*;
#(
    parameter int WORD_SIZE    = 32,
    parameter int ADDRESS_SIZE = 32,
    parameter int BASE_ADDR    = DEF_BASE_ADDR,
    parameter int MEM_WORDS    = DEF_MEM_WORDS,
    parameter int WAIT_CYCLES  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_read,
    input  logic                    req_write,
    input  logic [ADDRESS_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0]    req_wdata,
    output logic [WORD_SIZE-1:0]    rdata,
    output logic                    ready,
    output logic                    addr_fault,
    output logic [ADDRESS_SIZE-1:0] mem_Address,
    output logic [WORD_SIZE-1:0]    mem_WriteData,
    output logic                    mem_MemRead,
    output logic                    mem_MemWrite,
    input  logic [WORD_SIZE-1:0]    mem_ReadData
);

    localparam int CW = $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

    state_t state, state_nx;

    logic                    req_any;
    logic                    req_ok;
    logic                    cnt_load;
    logic                    cnt_dec;
    logic                    cnt_zero;
    logic [ADDRESS_SIZE-1:0] lat_addr;
    logic [WORD_SIZE-1:0]    lat_wdata;
    logic                    lat_write;

    assign req_any  = req_read | req_write;
    assign req_ok   = req_any && addr_in_range(64'(req_addr), 64'(BASE_ADDR), 64'(MEM_WORDS));
    assign cnt_load = (state == ST_IDLE) && req_ok;
    assign cnt_dec  = (state == ST_WAIT);

    mem_wait_counter #(
        .WIDTH (CW)
    ) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CNT_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (req_ok) state_nx = ST_WAIT;
            ST_WAIT: if (cnt_zero) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        ready         = 1'b0;
        addr_fault    = 1'b0;
        mem_Address   = '0;
        mem_WriteData = '0;
        mem_MemRead   = 1'b0;
        mem_MemWrite  = 1'b0;
        case (state)
            ST_IDLE: begin
                ready      = ~req_ok;
                addr_fault = req_any & ~req_ok;
            end
            ST_WAIT: begin
                mem_Address   = lat_addr;
                mem_WriteData = lat_wdata;
                mem_MemRead   = ~lat_write;
                // Write strobe only on the terminal count gives a single write edge.
                mem_MemWrite  = lat_write & cnt_zero;
            end
            ST_DONE: ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // A simultaneous read+write request is latched as a write, so rdata is left alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_write <= 1'b0;
            rdata     <= '0;
        end else if (state == ST_IDLE) begin
            if (req_ok) begin
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_write <= req_write;
            end else if (req_any) begin
                rdata <= '0;
            end
        end else if ((state == ST_WAIT) && cnt_zero && !lat_write) begin
            rdata <= mem_ReadData;
        end
    end

endmodule
